spi_burst_ctrl: RTL
===================

# spi_burst_ctrl

Sequencer that runs multi-byte SPI bursts through the existing byte-wide SPI master by driving that master's SFR bus on the host's behalf. It takes one command (SPCR value plus byte count) and then streams TX bytes in and RX bytes out over valid/ready handshakes. The host no longer bit-bangs SFR writes, polls SPIF or clears flags. It sits between the host pipe logic and the SPI master and is the only agent on the master's SFR bus.

## Interface
- LEN_W, 8: width of byte count; bursts of 0..2^LEN_W-1 bytes.
- TIMEOUT, 4096: max cycles to wait for SPIF per byte before abort (≥4).
- SPCR_ADDR / SPSR_ADDR / SPDR_ADDR, 8'h02 / 8'h03 / 8'h04: SFR addresses.

- CLK  in  1  system clock, shared with SPI master.
- RESET  in  1  reset RESET, asynchronous, active-high.
- cmd_valid / cmd_ready  in / out  1  command handshake; transfer on both high.
- cmd_spcr  in  8  SPCR value; bit 6 (SPE) is forced to 1 when written.
- cmd_len  in  LEN_W  byte count.
- tx_valid / tx_ready  in / out  1  TX byte handshake.
- tx_data  in  8  byte to send.
- rx_valid / rx_ready  out / in  1  RX byte handshake.
- rx_data  out  8  received byte, stable while rx_valid.
- done  out  1  one-cycle pulse, burst finished normally.
- err  out  1  one-cycle pulse, burst aborted on timeout.
- busy  out  1  high from command accept to done/err.
- spi_psel, spi_penable, spi_we, spi_re  out  1  SFR strobes to the master.
- spi_addr  out  8  SFR address; spi_wdata  out  8  SFR write data.
- spi_rdata  in  8  SFR read data (combinational on spi_addr in the master).

## Operation
- SFR write = one cycle with psel=1, penable=0, we=1, re=0. SFR read = addr held with psel=1, re=1, penable=0. Otherwise psel=we=re=0 and penable=0. All SFR outputs are registered.
- States: IDLE, CFG, FETCH, WDATA, POLL, CLR, READ, RXOUT, FIN.
- IDLE: cmd_ready=1. On accept, latch spcr|8'h40 and len, clear timeout counter → CFG.
- CFG: write SPCR. This also drops the master's SSn; the block never raises SSn. If len==0 → FIN, else → FETCH.
- FETCH: tx_ready=1. On tx_valid, latch tx_data → WDATA. Waits indefinitely.
- WDATA: write SPDR with the latched byte, clear timeout counter → POLL.
- POLL: read SPSR every cycle. If spi_rdata[0]=1 (SPIF) → CLR. Otherwise increment the counter. When the counter reaches TIMEOUT-1 without SPIF, pulse err, write nothing further → IDLE.
- CLR: write SPSR with 8'h01 (clear SPIF; WCOL is not touched) → READ.
- READ: addr=SPDR with a read strobe; capture spi_rdata into rx_data at the end of the cycle → RXOUT.
- RXOUT: rx_valid=1 until rx_ready. On handshake, decrement len. If the result is 0 → FIN, else → FETCH.
- FIN: pulse done → IDLE.
- Reset mid-burst: every state and output returns to reset values immediately; no SFR cycle is issued. The master resets independently on the same RESET.
- cmd_valid outside IDLE, tx_valid outside FETCH and rx_ready outside RXOUT are ignored.

## Timing
- Reset values: cmd_ready=0 during reset and 1 after; tx_ready=0, rx_valid=0, rx_data=0, done=0, err=0, busy=0, psel=we=re=penable=0, spi_addr=0, spi_wdata=0.
- Command accept → SPCR write strobe: 1 cycle.
- Per byte, excluding host stalls: FETCH 1 + WDATA 1 + POLL (master shift time + ≥3; the master sets SPIF ~3 cycles after the SPDR strobe) + CLR 1 + READ 1 + RXOUT ≥1.
- SPIF is never sampled in the cycle of the SPDR write; the first POLL sample is the cycle after.
- done and err are mutually exclusive and each last exactly 1 cycle. busy falls in the cycle after done/err.
- The len counter never wraps. Decrement happens only in RXOUT with len≥1.

## Test plan
- Loopback MISO=MOSI, cmd_spcr=8'h10, len=1, tx 8'hA5 → exactly one SPCR write of 8'h50, one SPDR write of 8'hA5, one SPSR write of 8'h01, rx_data=8'hA5, done one pulse, err=0.
- len=3, tx 8'h01/8'h80/8'hFF, rx_ready held low 20 cycles per byte → no second SPDR write until the first RX is accepted; rx order 01,80,FF; done after third handshake.
- len=0, cmd_spcr=8'h00 → one SPCR write (8'h40), no SPDR writes, done 2 cycles after accept, tx_ready never high.
- TIMEOUT=8, cmd_spcr=8'h03 (fosc/128), len=2 → err pulses after 8 POLL cycles, no CLR write, no rx_valid, back in IDLE with cmd_ready=1.
- tx_valid withheld 50 cycles in FETCH → SFR bus idle throughout, timeout counter not advancing, burst completes normally afterward.
- RESET asserted during POLL of byte 2 of 4 → all outputs at reset values in the same cycle; a new 1-byte command afterward completes correctly.

Source files
------------

// File: rtl/spi_burst_ctrl.sv
// rtl/spi_burst_ctrl.sv - Burst sequencer that drives a byte-wide SPI master over its SFR bus.
// One command (SPCR + length) then per-byte TX in / RX out handshakes; aborts on missing SPIF.
module spi_burst_ctrl #(
  parameter int         LEN_W     = 8,
  parameter int         TIMEOUT   = 4096,
  parameter logic [7:0] SPCR_ADDR = 8'h02,
  parameter logic [7:0] SPSR_ADDR = 8'h03,
  parameter logic [7:0] SPDR_ADDR = 8'h04
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_spcr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             spi_psel,
  output logic             spi_penable,
  output logic             spi_we,
  output logic             spi_re,
  output logic [7:0]       spi_addr,
  output logic [7:0]       spi_wdata,
  input  logic [7:0]       spi_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_FETCH, S_WDATA, S_POLL, S_CLR, S_READ, S_RXOUT, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       spcr_q, spcr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       txb_q, txb_d;
  logic [7:0]       rxd_q, rxd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             psel_q, psel_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             err_c;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      spcr_q  <= 8'h00;
      len_q   <= '0;
      txb_q   <= 8'h00;
      rxd_q   <= 8'h00;
      cnt_q   <= '0;
      psel_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      spcr_q  <= spcr_d;
      len_q   <= len_d;
      txb_q   <= txb_d;
      rxd_q   <= rxd_d;
      cnt_q   <= cnt_d;
      psel_q  <= psel_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    spcr_d  = spcr_q;
    len_d   = len_q;
    txb_d   = txb_q;
    rxd_d   = rxd_q;
    cnt_d   = cnt_q;
    err_c   = 1'b0;
    psel_d  = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = 8'h00;
    wdata_d = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          spcr_d  = cmd_spcr | 8'h40;
          len_d   = cmd_len;
          cnt_d   = '0;
          state_d = S_CFG;
        end
      end
      S_CFG:   state_d = (len_q == '0) ? S_FIN : S_FETCH;
      S_FETCH: begin
        if (tx_valid) begin
          txb_d   = tx_data;
          state_d = S_WDATA;
        end
      end
      S_WDATA: begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        if (spi_rdata[0]) begin
          state_d = S_CLR;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_c   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CLR:  state_d = S_READ;
      S_READ: begin
        rxd_d   = spi_rdata;
        state_d = S_RXOUT;
      end
      S_RXOUT: begin
        if (rx_ready) begin
          len_d   = len_q - LEN_W'(1);
          state_d = (len_q == LEN_W'(1)) ? S_FIN : S_FETCH;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // SFR strobes are registered, so they are decoded from the state being entered.
    case (state_d)
      S_CFG: begin
        psel_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = SPCR_ADDR;
        wdata_d = spcr_d;
      end
      S_WDATA: begin
        psel_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = SPDR_ADDR;
        wdata_d = txb_d;
      end
      S_POLL: begin
        psel_d = 1'b1;
        re_d   = 1'b1;
        addr_d = SPSR_ADDR;
      end
      S_CLR: begin
        psel_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = SPSR_ADDR;
        wdata_d = 8'h01;
      end
      S_READ: begin
        psel_d = 1'b1;
        re_d   = 1'b1;
        addr_d = SPDR_ADDR;
      end
      default: ;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE) && !RESET;
  assign tx_ready    = (state_q == S_FETCH);
  assign rx_valid    = (state_q == S_RXOUT);
  assign rx_data     = rxd_q;
  assign done        = (state_q == S_FIN);
  assign err         = err_c;
  assign busy        = (state_q != S_IDLE);
  assign spi_psel    = psel_q;
  assign spi_penable = 1'b0;
  assign spi_we      = we_q;
  assign spi_re      = re_q;
  assign spi_addr    = addr_q;
  assign spi_wdata   = wdata_q;

endmodule
